// File: rtl/video8bit_out_discontinuous_if.sv
// Read-side bundle between the video unpacker and the FWFT read FIFO / DDR reader.
// master = unpacker, slave = FIFO and DDR reader side.
interface video8bit_out_discontinuous_if #(
  parameter int unsigned ADDR_BITS = 25
);
  logic                 rd_fifo_en;
  logic [63:0]          rd_data;
  logic                 sync_fifo_empty;
  logic                 arst_fifo;
  logic                 loadbase;
  logic [ADDR_BITS-1:0] ddr_baseaddr;
  logic [23:0]          ddr_line_length;
  logic [11:0]          ddr_col_length;

  modport master (
    output rd_fifo_en, arst_fifo, loadbase, ddr_baseaddr, ddr_line_length, ddr_col_length,
    input  rd_data, sync_fifo_empty
  );

  modport slave (
    input  rd_fifo_en, arst_fifo, loadbase, ddr_baseaddr, ddr_line_length, ddr_col_length,
    output rd_data, sync_fifo_empty
  );
endinterface

// File: rtl/video8bit_out_discontinuous.sv
// Unpacks 64-bit FWFT FIFO words MSB-byte-first into an 8-bit pixel stream under an external vsync/de.
// Optional feature macro: VIDEO_OUT_UNDERFLOW_EN (sticky underflow flag, blanked underflow words).
module video8bit_out_discontinuous #(
  parameter int unsigned ADDR_BITS    = 25,
  parameter int unsigned FRAME_CYCLES = 8,
  parameter logic [7:0]  BLANK_VALUE  = 8'h00
) (
  input  logic                            pclk,
  input  logic                            prst,
  input  logic                            vsync,
  input  logic                            de,
  input  logic [ADDR_BITS-1:0]            baseaddr,
  input  logic [23:0]                     video_width,
  input  logic [11:0]                     video_height,
  video8bit_out_discontinuous_if.master   ddr,
  output logic                            ovsync,
  output logic                            ode,
  output logic [7:0]                      odata,
  output logic                            underflow
);

  typedef enum logic [1:0] {StIdle, StFrame, StActive, StFend} state_e;

  localparam logic [3:0] FrameLast = 4'(FRAME_CYCLES - 1);

  state_e               state_q, state_d;
  logic                 vsync_q;
  logic [ADDR_BITS-1:0] base_q, base_d, ddr_base_q, ddr_base_d;
  logic [23:0]          width_q, width_d, line_len_q, line_len_d, x_q, x_d;
  logic [11:0]          height_q, height_d, y_q, y_d;
  logic [3:0]           fcnt_q, fcnt_d;
  logic [2:0]           b_q, b_d;
  logic [63:0]          shreg_q, shreg_d;
  logic                 ode_q;
  logic [7:0]           odata_q, odata_d;
  logic                 pop, vs_rise, vs_fall;
  logic [7:0]           sh_byte;
`ifdef VIDEO_OUT_UNDERFLOW_EN
  logic                 uf_q, uf_d, bad_q, bad_d;
`endif

  always_comb begin
    vs_rise    = vsync & ~vsync_q;
    vs_fall    = vsync_q & ~vsync;
    // ~b selects bytes from the top: b=0 -> [63:56], b=7 -> [7:0]
    sh_byte    = shreg_q[{~b_q, 3'b000} +: 8];
    state_d    = state_q;
    base_d     = base_q;
    width_d    = width_q;
    height_d   = height_q;
    line_len_d = {3'b000, width_q[23:3]} + {23'd0, |width_q[2:0]};
    ddr_base_d = ddr_base_q;
    x_d        = x_q;
    y_d        = y_q;
    b_d        = b_q;
    fcnt_d     = fcnt_q;
    shreg_d    = shreg_q;
    odata_d    = BLANK_VALUE;
    pop        = 1'b0;
`ifdef VIDEO_OUT_UNDERFLOW_EN
    uf_d       = uf_q;
    bad_d      = bad_q;
`endif

    if (vsync) begin
      base_d   = baseaddr;
      width_d  = video_width;
      height_d = video_height;
    end

    unique case (state_q)
      StIdle: begin
        fcnt_d = '0;
        if (vs_fall) state_d = StFrame;
      end
      StFrame: begin
        ddr_base_d = base_q;
        x_d        = '0;
        y_d        = '0;
        b_d        = '0;
        fcnt_d     = fcnt_q + 4'd1;
        if (fcnt_q == FrameLast) state_d = StActive;
      end
      StActive: begin
        if (de && !vs_rise) begin
          if (b_q == 3'd0) begin
            if (!ddr.sync_fifo_empty) begin
              pop     = 1'b1;
              shreg_d = ddr.rd_data;
              odata_d = ddr.rd_data[63:56];
`ifdef VIDEO_OUT_UNDERFLOW_EN
              bad_d   = 1'b0;
`endif
            end else begin
`ifdef VIDEO_OUT_UNDERFLOW_EN
              bad_d   = 1'b1;
              uf_d    = 1'b1;
`endif
            end
          end else begin
`ifdef VIDEO_OUT_UNDERFLOW_EN
            odata_d = bad_q ? BLANK_VALUE : sh_byte;
`else
            odata_d = sh_byte;
`endif
          end
          b_d = b_q + 3'd1;
          x_d = x_q + 24'd1;
          // Line end drops any partial-word tail so the next line starts on a fresh word.
          if (x_q == width_q - 24'd1) begin
            b_d = '0;
            x_d = '0;
            y_d = y_q + 12'd1;
            if (y_q == height_q - 12'd1) state_d = StFend;
          end
        end
      end
      StFend: begin
      end
      default: state_d = StIdle;
    endcase

    if (vs_rise) state_d = StIdle;
`ifdef VIDEO_OUT_UNDERFLOW_EN
    if (state_q == StIdle && vs_fall) uf_d = 1'b0;
`endif
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q    <= StIdle;
      vsync_q    <= 1'b0;
      base_q     <= '0;
      width_q    <= '0;
      height_q   <= '0;
      line_len_q <= '0;
      ddr_base_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      b_q        <= '0;
      fcnt_q     <= '0;
      shreg_q    <= '0;
      ode_q      <= 1'b0;
      odata_q    <= BLANK_VALUE;
`ifdef VIDEO_OUT_UNDERFLOW_EN
      uf_q       <= 1'b0;
      bad_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      vsync_q    <= vsync;
      base_q     <= base_d;
      width_q    <= width_d;
      height_q   <= height_d;
      line_len_q <= line_len_d;
      ddr_base_q <= ddr_base_d;
      x_q        <= x_d;
      y_q        <= y_d;
      b_q        <= b_d;
      fcnt_q     <= fcnt_d;
      shreg_q    <= shreg_d;
      ode_q      <= de;
      odata_q    <= odata_d;
`ifdef VIDEO_OUT_UNDERFLOW_EN
      uf_q       <= uf_d;
      bad_q      <= bad_d;
`endif
    end
  end

  // Pop is decided from registered state and the current de so the FWFT head is consumed this cycle.
  assign ddr.rd_fifo_en      = pop;
  assign ddr.arst_fifo       = (state_q == StFrame) && (fcnt_q == 4'd0);
  assign ddr.loadbase        = (state_q == StFrame);
  assign ddr.ddr_baseaddr    = ddr_base_q;
  assign ddr.ddr_line_length = line_len_q;
  assign ddr.ddr_col_length  = height_q;
  assign ovsync              = vsync_q;
  assign ode                 = ode_q;
  assign odata               = odata_q;
`ifdef VIDEO_OUT_UNDERFLOW_EN
  assign underflow           = uf_q;
`else
  assign underflow           = 1'b0;
`endif

endmodule

// File: tb/tb_video8bit_out_discontinuous.sv
// Directed bench for video8bit_out_discontinuous: FWFT FIFO model, expected-pixel queue, per-cycle compare.
module tb_video8bit_out_discontinuous;
  localparam logic [7:0] BLANK = 8'h00;

  logic        pclk = 1'b0;
  logic        prst, vsync, de;
  logic [24:0] baseaddr;
  logic [23:0] video_width;
  logic [11:0] video_height;
  logic        ovsync, ode, underflow;
  logic [7:0]  odata;

  video8bit_out_discontinuous_if #(.ADDR_BITS(25)) ifc ();

  video8bit_out_discontinuous #(
    .ADDR_BITS(25), .FRAME_CYCLES(8), .BLANK_VALUE(8'h00)
  ) dut (
    .pclk(pclk), .prst(prst), .vsync(vsync), .de(de), .baseaddr(baseaddr),
    .video_width(video_width), .video_height(video_height), .ddr(ifc),
    .ovsync(ovsync), .ode(ode), .odata(odata), .underflow(underflow)
  );

  always #5 pclk = ~pclk;

  // FWFT FIFO: words written by the stimulus, head popped on rd_fifo_en, flushed on arst_fifo.
  logic [63:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;
  assign ifc.rd_data         = mem[rd_ptr % 64];
  assign ifc.sync_fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge pclk) begin
    if (ifc.arst_fifo) rd_ptr <= wr_ptr;
    else if (ifc.rd_fifo_en) begin
      pop_cnt <= pop_cnt + 1;
      if (rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
    end
  end

  int vectors = 0;
  int miscmp = 0;
  logic [7:0] exp_q[$];
  logic de_last = 1'b0;
  logic vs_last = 1'b0;
  int arst_cnt = 0;
  int load_cnt = 0;

  // Word k carries bytes {k[3:0], j} for j = 0..7, MSB first.
  function automatic logic [63:0] mk_word(input int k);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[63-8*j -: 8] = 8'(((k % 16) << 4) | j);
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs for one cycle, compare outputs mid-cycle, return 1 unit after the next posedge.
  task automatic step(input logic d, input logic v);
    logic [7:0] e;
    de = d;
    vsync = v;
    @(negedge pclk);
    chk("ode_delay", ode, de_last);
    chk("ovsync_delay", ovsync, vs_last);
    if (ode) begin
      if (exp_q.size() == 0) chk("exp_queue_nonempty", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("odata", odata, e);
      end
    end else chk("odata_idle", odata, BLANK);
    if (ifc.arst_fifo) arst_cnt++;
    if (ifc.loadbase) load_cnt++;
    de_last = d;
    vs_last = v;
    @(posedge pclk);
    #1;
  endtask

  // Pixel x of line l is byte x%8 of word tag0 + l*ceil(w/8) + x/8.
  task automatic model_push(input int w, input int h, input int tag0, input int limit);
    int llen;
    int n;
    llen = w / 8 + ((w % 8) != 0 ? 1 : 0);
    n = 0;
    for (int l = 0; l < h; l++)
      for (int x = 0; x < w; x++) begin
        if (n < limit) exp_q.push_back(8'((((tag0 + l * llen + x / 8) % 16) << 4) | (x % 8)));
        n++;
      end
  endtask

  task automatic frame_start(input int w, input int h, input int nload, input int nfde,
                             output int tag0);
    video_width  = 24'(w);
    video_height = 12'(h);
    baseaddr     = 25'(w * 4096 + h * 16 + 3);
    repeat (3) step(1'b0, 1'b1);
    arst_cnt = 0;
    load_cnt = 0;
    tag0 = wr_ptr;
    step(1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      if (k == 3)
        for (int i = 0; i < nload; i++) begin
          mem[wr_ptr % 64] = mk_word(wr_ptr);
          wr_ptr++;
        end
      if (k >= 4 && k < 4 + nfde) begin
        exp_q.push_back(BLANK);
        step(1'b1, 1'b0);
      end else step(1'b0, 1'b0);
    end
    chk("arst_pulses", arst_cnt, 1);
    chk("loadbase_cycles", load_cnt, 8);
    chk("ddr_baseaddr", ifc.ddr_baseaddr, baseaddr);
    chk("ddr_col_length", ifc.ddr_col_length, h);
    chk("ddr_line_length", ifc.ddr_line_length, w / 8 + ((w % 8) != 0 ? 1 : 0));
    chk("underflow_clear_on_frame", underflow, 1'b0);
  endtask

  // h lines of w de pixels, then one line past height that must stay blank.
  task automatic lines(input int w, input int h, input bit toggle);
    for (int l = 0; l < h; l++) begin
      for (int x = 0; x < w; x++) begin
        step(1'b1, 1'b0);
        if (toggle) step(1'b0, 1'b0);
      end
      repeat (3) step(1'b0, 1'b0);
    end
    repeat (4) begin
      exp_q.push_back(BLANK);
      step(1'b1, 1'b0);
    end
    repeat (2) step(1'b0, 1'b0);
  endtask

  initial begin
    int tag;
    int p0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    prst = 1'b1; de = 1'b0; vsync = 1'b0;
    baseaddr = '0; video_width = '0; video_height = '0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_ode", ode, 1'b0);
    chk("rst_odata", odata, BLANK);
    chk("rst_ovsync", ovsync, 1'b0);
    chk("rst_rd_fifo_en", ifc.rd_fifo_en, 1'b0);
    chk("rst_arst_fifo", ifc.arst_fifo, 1'b0);
    chk("rst_loadbase", ifc.loadbase, 1'b0);
    chk("rst_underflow", underflow, 1'b0);
    chk("rst_line_length", ifc.ddr_line_length, 0);
    chk("rst_col_length", ifc.ddr_col_length, 0);
    chk("rst_baseaddr", ifc.ddr_baseaddr, 0);
    prst = 1'b0;

    // T1: width 16, height 2, 4 words
    p0 = pop_cnt;
    frame_start(16, 2, 4, 0, tag);
    model_push(16, 2, tag, 1 << 30);
    chk("t1_model_b0", exp_q[0], 8'h00);
    chk("t1_model_b9", exp_q[9], 8'h11);
    chk("t1_model_b31", exp_q[31], 8'h37);
    lines(16, 2, 1'b0);
    chk("t1_pops", pop_cnt - p0, 4);
    chk("t1_drained", exp_q.size(), 0);
    step(1'b0, 1'b1);

    // T4: width 9 -> 2 words per line; de during the reload window stays blank
    p0 = pop_cnt;
    frame_start(9, 2, 4, 4, tag);
    chk("t4_line_length", ifc.ddr_line_length, 2);
    chk("t4_col_length", ifc.ddr_col_length, 2);
    chk("t4_no_pop_in_frame", pop_cnt - p0, 0);
    model_push(9, 2, tag, 1 << 30);
    lines(9, 2, 1'b0);
    chk("t4_pops", pop_cnt - p0, 4);
    chk("t4_drained", exp_q.size(), 0);
    step(1'b0, 1'b1);

    // T2: width 10, partial second word per line
    p0 = pop_cnt;
    frame_start(10, 2, 4, 0, tag);
    model_push(10, 2, tag, 1 << 30);
    chk("t2_model_b9", exp_q[9], 8'h91);
    chk("t2_model_b10", exp_q[10], 8'hA0);
    lines(10, 2, 1'b0);
    chk("t2_pops", pop_cnt - p0, 4);
    chk("t2_drained", exp_q.size(), 0);
    step(1'b0, 1'b1);

    // T3: width 8 with de toggling every cycle
    p0 = pop_cnt;
    frame_start(8, 1, 1, 0, tag);
    model_push(8, 1, tag, 1 << 30);
    lines(8, 1, 1'b1);
    chk("t3_pops", pop_cnt - p0, 1);
    chk("t3_drained", exp_q.size(), 0);
    step(1'b0, 1'b1);

    // T5: empty FIFO at line start; stale register still holds the T3 word (tag 12)
    p0 = pop_cnt;
    frame_start(8, 1, 0, 0, tag);
`ifdef VIDEO_OUT_UNDERFLOW_EN
    repeat (8) exp_q.push_back(BLANK);
`else
    exp_q.push_back(BLANK);
    for (int j = 1; j < 8; j++) exp_q.push_back(8'((12 << 4) | j));
    chk("t5_model_stale_b1", exp_q[1], 8'hC1);
`endif
    lines(8, 1, 1'b0);
    chk("t5_pops", pop_cnt - p0, 0);
    chk("t5_drained", exp_q.size(), 0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
`ifdef VIDEO_OUT_UNDERFLOW_EN
    chk("t5_underflow_sticky", underflow, 1'b1);
`else
    chk("t5_underflow_off", underflow, 1'b0);
`endif

    // T6a: vsync rise mid-line aborts; de while vsync high never pops
    p0 = pop_cnt;
    frame_start(16, 2, 4, 0, tag);
    model_push(16, 2, tag, 5);
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    repeat (3) begin
      exp_q.push_back(BLANK);
      step(1'b1, 1'b1);
    end
    step(1'b0, 1'b1);
    chk("t6_rise_pops", pop_cnt - p0, 1);
    chk("t6_rise_drained", exp_q.size(), 0);

    // T6b: prst mid-line returns everything to reset values
    p0 = pop_cnt;
    frame_start(16, 1, 2, 0, tag);
    model_push(16, 1, tag, 3);
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    prst = 1'b1;
    step(1'b0, 1'b0);
    chk("t6_rst_ode", ode, 1'b0);
    chk("t6_rst_odata", odata, BLANK);
    chk("t6_rst_loadbase", ifc.loadbase, 1'b0);
    chk("t6_rst_line_length", ifc.ddr_line_length, 0);
    chk("t6_rst_col_length", ifc.ddr_col_length, 0);
    chk("t6_rst_baseaddr", ifc.ddr_baseaddr, 0);
    chk("t6_rst_underflow", underflow, 1'b0);
    prst = 1'b0;
    chk("t6_prst_pops_before", pop_cnt - p0, 1);
    p0 = pop_cnt;
    repeat (4) begin
      exp_q.push_back(BLANK);
      step(1'b1, 1'b0);
    end
    step(1'b0, 1'b0);
    chk("t6_prst_no_pops", pop_cnt - p0, 0);
    chk("t6_prst_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end
endmodule
